// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time onto a byte-wide,
// big-endian data memory and returns a sign/zero-extended 32-bit result.
module load_store_unit #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWr,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqWdata,
  output logic              rspValid,
  output logic [31:0]       rspData,
  output logic              rspErr,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  output logic              memWr,
  output logic [7:0]        memWdata,
  input  logic [7:0]        memRdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDLAST,
    WR,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base;
  logic [1:0]        cnt;
  logic [1:0]        last_cnt;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [31:0]       wsh;
  logic [23:0]       acc;

  logic              accept;
  logic              last_beat;
  logic              req_err;
  logic [1:0]        req_last;
  logic [31:0]       wd_align;
  logic [31:0]       rd_full;
  logic [31:0]       rd_res;

  assign accept    = reqValid & reqReady;
  assign last_beat = (cnt == last_cnt);
  assign rd_full   = {acc, memRdata};

  // Store data is left-aligned so the MSB byte always leaves first.
  always_comb begin
    req_err  = 1'b0;
    req_last = 2'd0;
    wd_align = 32'h0;
    unique case (reqSize)
      2'b00: begin
        req_last = 2'd0;
        wd_align = {reqWdata[7:0], 24'h0};
      end
      2'b01: begin
        req_last = 2'd1;
        wd_align = {reqWdata[15:0], 16'h0};
        req_err  = reqAddr[0];
      end
      2'b10: begin
        req_last = 2'd3;
        wd_align = reqWdata;
        req_err  = |reqAddr[1:0];
      end
      default: req_err = 1'b1;
    endcase
    if (|reqAddr[31:ADDR_W]) req_err = 1'b1;
  end

  always_comb begin
    rd_res = rd_full;
    unique case (size_q)
      2'b00: rd_res = sgn_q ? {{24{rd_full[7]}}, rd_full[7:0]}
                            : {24'h0, rd_full[7:0]};
      2'b01: rd_res = sgn_q ? {{16{rd_full[15]}}, rd_full[15:0]}
                            : {16'h0, rd_full[15:0]};
      default: rd_res = rd_full;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)    state_nxt = DONE;
          else if (reqWr) state_nxt = WR;
          else            state_nxt = RD;
        end
      end
      RD:      if (last_beat) state_nxt = RDLAST;
      RDLAST:  state_nxt = DONE;
      WR:      if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reqReady = 1'b0;
    rspValid = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    memAddr  = '0;
    memWdata = 8'h0;
    unique case (1'b1)
      (state == IDLE): reqReady = 1'b1;
      (state == RD): begin
        memRd   = 1'b1;
        memAddr = base + ADDR_W'(cnt);
      end
      (state == WR): begin
        memWr    = 1'b1;
        memAddr  = base + ADDR_W'(cnt);
        memWdata = wsh[31:24];
      end
      (state == DONE): rspValid = 1'b1;
      default: ;
    endcase
  end

  // Read data lags its strobe by a cycle, so beat 0 is not shifted in.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      base     <= '0;
      cnt      <= 2'd0;
      last_cnt <= 2'd0;
      size_q   <= 2'd0;
      sgn_q    <= 1'b0;
      wsh      <= 32'h0;
      acc      <= 24'h0;
      rspData  <= 32'h0;
      rspErr   <= 1'b0;
    end else begin
      if (accept) begin
        base     <= reqAddr[ADDR_W-1:0];
        cnt      <= 2'd0;
        last_cnt <= req_last;
        size_q   <= reqSize;
        sgn_q    <= reqSigned;
        wsh      <= wd_align;
        acc      <= 24'h0;
        if (req_err) begin
          rspData <= 32'h0;
          rspErr  <= 1'b1;
        end
      end
      if (state == WR) begin
        wsh <= {wsh[23:0], 8'h0};
        cnt <= cnt + 2'd1;
        if (last_beat) begin
          rspData <= 32'h0;
          rspErr  <= 1'b0;
        end
      end
      if (state == RD) begin
        cnt <= cnt + 2'd1;
        if (cnt != 2'd0) acc <= {acc[15:0], memRdata};
      end
      if (state == RDLAST) begin
        rspData <= rd_res;
        rspErr  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store initiator for the multi-cycle CPU. Accepts one load or store request at a time from the control unit and sequences it onto the byte-wide, single-port data memory, one byte per cycle, big-endian. It assembles and sign-extends read bytes into a 32-bit result and reports alignment and range errors. It is the requesting end of the data-memory port; the data memory is the responder.

## Interface
- ADDR_W, 7, byte-address width of the data memory (2^ADDR_W bytes; default 128)
- clk  in  1  clock; all state changes on rising edge
- rstN  in  1  reset; asynchronous, active-low
- reqValid  in  1  request present
- reqReady  out  1  unit can accept a request
- reqWr  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- reqSigned  in  1  sign-extend loads (byte/half only)
- reqAddr  in  32  byte address
- reqWdata  in  32  store data, right-justified
- rspValid  out  1  one-cycle completion pulse
- rspData  out  32  load result (0 for stores and errors)
- rspErr  out  1  request rejected, no memory access made
- memAddr  out  ADDR_W  memory byte address
- memRd  out  1  read strobe
- memWr  out  1  write strobe
- memWdata  out  8  write byte
- memRdata  in  8  read byte, valid the cycle after memRd (one-cycle latency)

## Operation
- States: IDLE, RD, RDLAST, WR, DONE. reqReady = 1 only in IDLE.
- Accept on reqValid & reqReady; all req* fields captured at accept, later changes ignored.
- Beat count n = 1/2/4 for byte/half/word.
- Error if: reqSize = 11; half with reqAddr[0] ≠ 0; word with reqAddr[1:0] ≠ 0; reqAddr[31:ADDR_W] ≠ 0. Error goes IDLE → DONE, no strobes; rspErr = 1, rspData = 0.
- Big-endian: byte at the lowest address is the most significant byte of the datum. Word store: addr ← wdata[31:24], +1 ← [23:16], +2 ← [15:8], +3 ← [7:0]. Half: addr ← [15:8], +1 ← [7:0]. Byte: addr ← [7:0].
- WR: n cycles, beat k drives memWr = 1, memAddr = addr + k, memWdata = byte k; then DONE.
- RD: n cycles, beat k drives memRd = 1, memAddr = addr + k. Byte returned for beat k is shifted into an accumulator in the following cycle. RDLAST: 1 cycle capturing the final byte, no strobe. Then DONE.
- Load result: word as assembled. Half/byte are zero-extended, or sign-extended from bit 15/7 when reqSigned = 1.
- DONE: rspValid = 1 for one cycle, then IDLE.
- rspData/rspErr are registered and hold until the next rspValid.
- When no strobe is active, memAddr = 0 and memWdata = 0. memRd and memWr are never both 1.

## Timing
- Accept cycle = cycle 0.
- Word load: memRd cycles 1–4, RDLAST cycle 5, rspValid cycle 6.
- Half load: rspValid cycle 4. Byte load: rspValid cycle 3.
- Word store: memWr cycles 1–4, rspValid cycle 5. Half store: rspValid cycle 3. Byte store: rspValid cycle 2.
- Error: rspValid cycle 1.
- reqReady returns to 1 the cycle after DONE. Back-to-back throughput = latency + 1.
- Reset values: state IDLE, reqReady = 1; rspValid, rspErr, memRd, memWr = 0; rspData, memAddr, memWdata = 0.
- Reset asserted mid-operation: strobes drop immediately (asynchronous), no rspValid is produced, and bytes already written stay written.
- reqValid while busy: ignored, not queued; the requester must hold it until reqReady.

## Test plan
- After reset: word store 0x12345678 to 0x10 → memWr cycles 1–4 with addr 0x10..0x13 and bytes 12, 34, 56, 78; rspValid cycle 5; rspErr = 0.
- Word load from 0x10 after that store → memRd cycles 1–4, rspData = 0x12345678 on cycle 6.
- Signed byte load from 0x13 holding 0x80 → 0xFFFFFF80; unsigned → 0x00000080. Signed half load from 0x12 holding 0x8001 → 0xFFFF8001.
- Errors: word load at 0x11, half at 0x03, reqSize = 11, reqAddr = 0x80 → each gives rspValid cycle 1, rspErr = 1, rspData = 0, no memRd/memWr.
- Back-to-back: byte store then byte load with reqValid held high → second accept one cycle after the first rspValid; reqReady = 0 throughout the busy period.
- Assert rstN low during beat 2 of a word store → strobes drop at once, no rspValid, reqReady = 1 after release, bytes 0 and 1 already in memory.
